// File: rtl/noc_stat_pkg.sv
// noc_stat_pkg: shared types and width helpers for the router statistics dump path
package noc_stat_pkg;
    typedef enum logic {IDLE, DUMP} dump_state_e;
    localparam int REC_ID_W = 8;
    localparam int REC_CNT_W = 64;
    typedef struct packed {
        logic [REC_ID_W-1:0]  rid;
        logic [REC_ID_W-1:0]  pid;
        logic [REC_CNT_W-1:0] flit_cnt;
        logic [REC_CNT_W-1:0] pck_cnt;
        logic                 last;
    } stat_dump_rec_t;
    function automatic int rid_w(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction
    function automatic int pid_w(input int max_p);
        return (max_p > 1) ? $clog2(max_p) : 1;
    endfunction
endpackage

// File: rtl/stat_counter_bank.sv
// stat_counter_bank: saturating live/shadow counter pairs with snapshot-and-clear and indexed readout
module stat_counter_bank #(
    parameter int N     = 80,
    parameter int CNT_W = 32,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     flit_event,
    input  logic [N-1:0]     pck_event,
    input  logic             snap,
    input  logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] flit_cnt,
    output logic [CNT_W-1:0] pck_cnt
);
    logic [CNT_W-1:0] flit_live [N];
    logic [CNT_W-1:0] pck_live [N];
    logic [CNT_W-1:0] flit_shadow [N];
    logic [CNT_W-1:0] pck_shadow [N];
    // On a snapshot the live counter restarts from the event of that same cycle
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic ev, input logic clr);
        return clr ? CNT_W'(ev) : (ev && c != '1) ? c + CNT_W'(1) : c;
    endfunction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                flit_live[i]   <= '0;
                pck_live[i]    <= '0;
                flit_shadow[i] <= '0;
                pck_shadow[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                flit_live[i]   <= bump(flit_live[i], flit_event[i], snap);
                pck_live[i]    <= bump(pck_live[i], pck_event[i], snap);
                flit_shadow[i] <= snap ? flit_live[i] : flit_shadow[i];
                pck_shadow[i]  <= snap ? pck_live[i] : pck_shadow[i];
            end
        end
    end
    assign flit_cnt = flit_shadow[idx];
    assign pck_cnt  = pck_shadow[idx];
endmodule

// File: rtl/router_stat_dump_ctrl.sv
// router_stat_dump_ctrl: windowed per-router/port flit and packet statistics with streamed snapshot dump
module router_stat_dump_ctrl
    import noc_stat_pkg::*;
#(
    parameter int NR     = 16,
    parameter int MAX_P  = 5,
    parameter int CNT_W  = 32,
    parameter int PERIOD = 0,
    parameter int OVR_W  = 16,
    localparam int RID_W = rid_w(NR),
    localparam int PID_W = pid_w(MAX_P)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NR*MAX_P-1:0] flit_event,
    input  logic [NR*MAX_P-1:0] pck_event,
    input  logic                print_req,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [RID_W-1:0]    dump_rid,
    output logic [PID_W-1:0]    dump_pid,
    output logic [CNT_W-1:0]    dump_flit_cnt,
    output logic [CNT_W-1:0]    dump_pck_cnt,
    output logic                dump_last,
    output logic                busy,
    output logic [OVR_W-1:0]    overrun_cnt
);
    localparam int N     = NR * MAX_P;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    dump_state_e      state, state_n;
    logic [RID_W-1:0] rid, rid_n;
    logic [PID_W-1:0] pid, pid_n;
    logic [PER_W-1:0] period_cnt;
    logic [OVR_W-1:0] ovr_n;
    logic             pending, pending_n, prev_req;
    logic             period_hit, trig, hs, at_last, snap;
    logic [IDX_W-1:0] idx;
    assign period_hit = (PERIOD > 0) && (period_cnt == PER_W'(PERIOD - 1));
    assign trig       = (print_req && !prev_req) || period_hit;
    assign busy       = (state == DUMP);
    assign dump_valid = busy;
    assign hs         = busy && dump_ready;
    assign at_last    = (rid == RID_W'(NR - 1)) && (pid == PID_W'(MAX_P - 1));
    assign dump_last  = busy && at_last;
    assign dump_rid   = rid;
    assign dump_pid   = pid;
    assign idx        = IDX_W'(rid) * IDX_W'(MAX_P) + IDX_W'(pid);
    stat_counter_bank #(.N(N), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_bank (
        .clk        (clk),
        .reset      (reset),
        .flit_event (flit_event),
        .pck_event  (pck_event),
        .snap       (snap),
        .idx        (idx),
        .flit_cnt   (dump_flit_cnt),
        .pck_cnt    (dump_pck_cnt)
    );
    // A trigger coinciding with the final handshake is treated as pending and serviced immediately
    always_comb begin
        state_n   = state;
        rid_n     = rid;
        pid_n     = pid;
        pending_n = pending;
        ovr_n     = overrun_cnt;
        snap      = 1'b0;
        if (state == IDLE) begin
            snap    = trig;
            state_n = trig ? DUMP : IDLE;
            rid_n   = trig ? '0 : rid;
            pid_n   = trig ? '0 : pid;
        end else begin
            if (trig && pending)
                ovr_n = (overrun_cnt == '1) ? overrun_cnt : overrun_cnt + OVR_W'(1);
            if (trig && !pending)
                pending_n = 1'b1;
            if (hs) begin
                pid_n = (pid == PID_W'(MAX_P - 1)) ? '0 : pid + PID_W'(1);
                rid_n = (pid == PID_W'(MAX_P - 1)) ? rid + RID_W'(1) : rid;
                if (at_last) begin
                    rid_n     = '0;
                    pid_n     = '0;
                    pending_n = 1'b0;
                    snap      = pending || trig;
                    state_n   = (pending || trig) ? DUMP : IDLE;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rid         <= '0;
            pid         <= '0;
            pending     <= 1'b0;
            prev_req    <= 1'b0;
            period_cnt  <= '0;
            overrun_cnt <= '0;
        end else begin
            state       <= state_n;
            rid         <= rid_n;
            pid         <= pid_n;
            pending     <= pending_n;
            prev_req    <= print_req;
            period_cnt  <= (period_hit || PERIOD == 0) ? '0 : period_cnt + PER_W'(1);
            overrun_cnt <= ovr_n;
        end
    end
endmodule

// File: tb/tb_router_stat_dump_ctrl.sv
// tb_router_stat_dump_ctrl: scoreboard bench for the statistics dump controller
module tb_router_stat_dump_ctrl;
    typedef struct packed {
        logic       rid;
        logic       pid;
        logic [3:0] f;
        logic [3:0] p;
        logic       last;
    } rec_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    rec_t exp_q[$];
    logic       rstn0, req, dr, dv, rid, pid, last, busy;
    logic [3:0] flit, pck, fcnt, pcnt;
    logic [7:0] ovr;
    logic       rstn1, p_req, p_dv, p_rid, p_pid, p_last, p_busy;
    logic [3:0] p_flit;
    logic [7:0] p_fcnt, p_pcnt, p_ovr;
    router_stat_dump_ctrl #(.NR(2), .MAX_P(2), .CNT_W(4), .PERIOD(0), .OVR_W(8)) u0 (
        .clk(clk), .reset(rstn0), .flit_event(flit), .pck_event(pck), .print_req(req),
        .dump_valid(dv), .dump_ready(dr), .dump_rid(rid), .dump_pid(pid),
        .dump_flit_cnt(fcnt), .dump_pck_cnt(pcnt), .dump_last(last), .busy(busy), .overrun_cnt(ovr)
    );
    router_stat_dump_ctrl #(.NR(2), .MAX_P(2), .CNT_W(8), .PERIOD(8), .OVR_W(8)) u1 (
        .clk(clk), .reset(rstn1), .flit_event(p_flit), .pck_event(4'b0000), .print_req(p_req),
        .dump_valid(p_dv), .dump_ready(1'b1), .dump_rid(p_rid), .dump_pid(p_pid),
        .dump_flit_cnt(p_fcnt), .dump_pck_cnt(p_pcnt), .dump_last(p_last), .busy(p_busy), .overrun_cnt(p_ovr)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // nibble i of f/p is the expected count of record i (rid=i/2, pid=i%2)
    task automatic push_dump(input logic [15:0] f, input logic [15:0] p);
        for (int i = 0; i < 4; i++)
            exp_q.push_back(rec_t'({i[1], i[0], f[i*4 +: 4], p[i*4 +: 4], i == 3}));
    endtask
    task automatic pulse(input logic [3:0] fm, input logic [3:0] pm, input int n);
        flit = fm;
        pck = pm;
        repeat (n) tick();
        flit = '0;
        pck = '0;
    endtask
    task automatic trigger();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask
    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'h0);
    endtask
    always @(negedge clk) begin
        if (dv && dr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record: got rid=%0d pid=%0d flit=%0d with no record expected", rid, pid, fcnt);
            end else begin
                check("record", 32'({rid, pid, fcnt, pcnt, last}), 32'(exp_q.pop_front()));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int quiet;
        rstn0 = 1'b0; rstn1 = 1'b0; req = 1'b0; dr = 1'b0; flit = '0; pck = '0;
        p_req = 1'b0; p_flit = '0;
        #1;
        check("async_reset_valid", 32'({dv, busy}), 32'h0);
        tick();
        tick();
        rstn0 = 1'b1;
        check("reset_outputs", 32'({dv, busy, rid, pid, last, fcnt, pcnt}), 32'h0);
        check("reset_overrun", 32'(ovr), 32'h0);
        // basic dump of three events on record 1
        dr = 1'b1;
        pulse(4'b0010, 4'b0000, 3);
        push_dump(16'h0030, 16'h0000);
        trigger();
        check("valid_at_t_plus_1", 32'(dv), 32'h1);
        repeat (3) tick();
        check("valid_through_rec3", 32'({dv, last}), 32'h3);
        tick();
        check("idle_after_4", 32'(busy), 32'h0);
        // event in the trigger cycle goes to the next window
        pulse(4'b0001, 4'b1000, 2);
        pulse(4'b0001, 4'b0000, 3);
        push_dump(16'h0005, 16'h2000);
        flit = 4'b0001;
        trigger();
        flit = '0;
        wait_idle("idle_t2a");
        push_dump(16'h0001, 16'h0000);
        trigger();
        wait_idle("idle_t2b");
        // saturation at 15
        pulse(4'b0100, 4'b0100, 20);
        push_dump(16'h0F00, 16'h0F00);
        trigger();
        wait_idle("idle_t3");
        // backpressure holds record 1
        pulse(4'b0010, 4'b0000, 2);
        pulse(4'b0100, 4'b0000, 7);
        push_dump(16'h0720, 16'h0000);
        trigger();
        tick();
        dr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("hold_fields", 32'({dv, rid, pid, fcnt, last}), 32'({1'b1, 1'b0, 1'b1, 4'd2, 1'b0}));
            tick();
        end
        dr = 1'b1;
        wait_idle("idle_t4");
        // three triggers in one dump: one pending, one overrun
        dr = 1'b0;
        pulse(4'b1000, 4'b0000, 4);
        push_dump(16'h4000, 16'h0000);
        push_dump(16'h0003, 16'h0000);
        trigger();
        pulse(4'b0001, 4'b0000, 2);
        trigger();
        pulse(4'b0001, 4'b0000, 1);
        trigger();
        check("overrun_one", 32'(ovr), 32'h1);
        dr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("no_valid_gap", 32'(dv), 32'h1);
            tick();
        end
        check("idle_t5", 32'(busy), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        // periodic instance
        rstn1 = 1'b1;
        p_flit = 4'b0010;
        tick();
        tick();
        p_flit = '0;
        repeat (5) tick();
        check("period_quiet", 32'({p_dv, p_busy}), 32'h0);
        tick();
        check("period_fire_7", 32'({p_dv, p_rid, p_pid}), 32'h4);
        tick();
        check("period_rec1", 32'({p_pid, p_fcnt}), 32'h102);
        repeat (3) tick();
        check("period_end", 32'(p_dv), 32'h0);
        repeat (3) tick();
        p_req = 1'b1;
        tick();
        p_req = 1'b0;
        check("period_fire_15", 32'(p_dv), 32'h1);
        repeat (4) tick();
        check("merged_single_dump", 32'({p_dv, p_ovr}), 32'h0);
        repeat (4) tick();
        check("period_fire_23", 32'(p_dv), 32'h1);
        tick();
        rstn1 = 1'b0;
        #1;
        check("reset_drops_valid", 32'({p_dv, p_busy, p_pid}), 32'h0);
        tick();
        tick();
        rstn1 = 1'b1;
        quiet = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            quiet += int'(p_dv);
        end
        check("no_output_after_reset", 32'(quiet), 32'h0);
        tick();
        check("fire_after_reset", 32'(p_dv), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
